// File: rtl/xor_apuf_eval_ctrl.sv
// XOR arbiter-PUF evaluator: race launch/settle/sample sequencing; APUF_MAJORITY_VOTE_EN enables N_VOTE majority voting.
// Accept to resp_valid takes N_EVAL*(SETTLE_CYC+3) cycles; one challenge in flight; response held in DONE until resp_ready.

module apuf #(
  parameter int CHAL_W = 243,
  parameter int IDX    = 0
) (
  input  logic              X,
  input  logic              Y,
  input  logic [CHAL_W-1:0] Chal,
  output logic              PUF_out
);
  // Behavioural stand-in for one delay chain; the per-instance bias models process variation.
  localparam logic BIAS = 1'(IDX % 2);

  assign PUF_out = X & Y & ((^Chal) ^ BIAS);
endmodule

module xor_apuf_eval_ctrl #(
  parameter int CHAL_W     = 243,
  parameter int N_CHAINS   = 243,
  parameter int SETTLE_CYC = 8,
  parameter int N_VOTE     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CHAL_W-1:0] chal_in,
  input  logic              chal_valid,
  output logic              chal_ready,
  output logic              resp_out,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [3:0]        resp_conf,
  output logic              busy
);
`ifdef APUF_MAJORITY_VOTE_EN
  localparam int N_EVAL = N_VOTE;
`else
  localparam int N_EVAL = 1;
`endif
  localparam int         SW          = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC);
  localparam logic [SW-1:0] LAST_SETTLE = SW'(SETTLE_CYC - 1);
  localparam logic [3:0] LAST_EVAL   = 4'(N_EVAL - 1);
  localparam logic [3:0] MAJ         = 4'(N_EVAL / 2);

  if (N_CHAINS < 1 || SETTLE_CYC < 1 || N_VOTE < 1 || N_VOTE > 15 || (N_VOTE % 2) == 0) begin : g_param_err
    $error("xor_apuf_eval_ctrl: illegal parameter set");
  end

  typedef enum logic [2:0] {S_IDLE, S_APPLY, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CHAL_W-1:0]   chal_reg_q, chal_reg_d;
  logic                launch_q, launch_d;
  logic                sync1_q, sync1_d, sync2_q, sync2_d;
  logic [SW-1:0]       settle_cnt_q, settle_cnt_d;
  logic                smp_cnt_q, smp_cnt_d;
  logic [3:0]          eval_cnt_q, eval_cnt_d;
  logic [3:0]          ones_q, ones_d;
  logic                resp_out_q, resp_out_d;
  logic [3:0]          resp_conf_q, resp_conf_d;
  logic [3:0]          ones_inc, eval_inc;

  logic [N_CHAINS-1:0] puf_out;
  (* dont_touch = "true" *) logic puf_xor;

  // Every chain must survive synthesis even though the behavioural models look alike.
  for (genvar i = 0; i < N_CHAINS; i++) begin : g_chain
    (* dont_touch = "true" *)
    apuf #(.CHAL_W(CHAL_W), .IDX(i)) u_apuf (
      .X      (launch_q),
      .Y      (launch_q),
      .Chal   (chal_reg_q),
      .PUF_out(puf_out[i])
    );
  end

  assign puf_xor = ^puf_out;

  always_comb begin
    state_d      = state_q;
    chal_reg_d   = chal_reg_q;
    settle_cnt_d = settle_cnt_q;
    smp_cnt_d    = smp_cnt_q;
    eval_cnt_d   = eval_cnt_q;
    ones_d       = ones_q;
    resp_out_d   = resp_out_q;
    resp_conf_d  = resp_conf_q;
    sync1_d      = puf_xor;
    sync2_d      = sync1_q;
    ones_inc     = (ones_q == 4'hF) ? ones_q : ones_q + {3'b000, sync2_q};
    eval_inc     = (eval_cnt_q == 4'hF) ? eval_cnt_q : eval_cnt_q + 4'd1;

    case (state_q)
      S_IDLE: begin
        if (chal_valid) begin
          chal_reg_d = chal_in;
          eval_cnt_d = 4'd0;
          ones_d     = 4'd0;
          state_d    = S_APPLY;
        end
      end
      S_APPLY: begin
        settle_cnt_d = '0;
        state_d      = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_cnt_q == LAST_SETTLE) begin
          smp_cnt_d = 1'b0;
          state_d   = S_SAMPLE;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      S_SAMPLE: begin
        // Second cycle: the synchroniser output now reflects the settled race.
        if (!smp_cnt_q) begin
          smp_cnt_d = 1'b1;
        end else begin
          ones_d     = ones_inc;
          eval_cnt_d = eval_inc;
          if (eval_cnt_q == LAST_EVAL) begin
            resp_out_d  = (ones_inc > MAJ);
            resp_conf_d = ones_inc;
            state_d     = S_DONE;
          end else begin
            state_d = S_APPLY;
          end
        end
      end
      S_DONE: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Launch drops for the APPLY cycle to reset the arbiters, then stays high through sampling.
    launch_d = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      chal_reg_q   <= '0;
      launch_q     <= 1'b0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      settle_cnt_q <= '0;
      smp_cnt_q    <= 1'b0;
      eval_cnt_q   <= 4'd0;
      ones_q       <= 4'd0;
      resp_out_q   <= 1'b0;
      resp_conf_q  <= 4'd0;
    end else begin
      state_q      <= state_d;
      chal_reg_q   <= chal_reg_d;
      launch_q     <= launch_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      settle_cnt_q <= settle_cnt_d;
      smp_cnt_q    <= smp_cnt_d;
      eval_cnt_q   <= eval_cnt_d;
      ones_q       <= ones_d;
      resp_out_q   <= resp_out_d;
      resp_conf_q  <= resp_conf_d;
    end
  end

  assign chal_ready = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = (state_q == S_DONE);
  assign resp_out   = resp_out_q;
  assign resp_conf  = resp_conf_q;
endmodule
